// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared helpers for the Hamming SEC/SECDED decoder: codeword geometry
// (parity width, Hamming width, total code width), data-bit placement and the
// error classification type used by the syndrome decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package hamming_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_UNCORR = 2'd2
    } err_class_e;

    // Smallest p with 2^p >= data_w + p + 1. Scanned downward so the last hit
    // is the smallest qualifying p.
    function automatic int parity_width(input int data_w);
        int r;
        r = 0;
        for (int p = 30; p >= 1; p--) begin
            if ((1 << p) >= data_w + p + 1) r = p;
        end
        return r;
    endfunction

    function automatic int hamming_width(input int data_w);
        return data_w + parity_width(data_w);
    endfunction

    function automatic int code_width(input int data_w, input int secded);
        return hamming_width(data_w) + ((secded != 0) ? 1 : 0);
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Codeword position (1-based) of data bit idx. Non-power-of-two positions
    // are dense, so 2*idx+8 always bounds the search.
    function automatic int data_pos(input int idx);
        int cnt;
        int r;
        cnt = 0;
        r   = 0;
        for (int pos = 3; pos <= 2 * idx + 8; pos++) begin
            if (!is_pow2(pos)) begin
                if (cnt == idx) r = pos;
                cnt++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hamming_syndrome_decode.sv
// -----------------------------------------------------------------------------
// hamming_syndrome_decode
// Combinational classification of a syndrome (and, in SECDED mode, the overall
// parity q) into clean / single / uncorrectable, plus a one-hot flip mask over
// the Hamming positions.
// Ports:
//   i_syn         P_W  raw syndrome
//   i_q           1    overall parity of the received codeword
//   o_flip_mask   H_W  one-hot bit to invert (all zero when nothing to flip)
//   o_err_single  1    single error detected/corrected
//   o_err_uncorr  1    uncorrectable error
// -----------------------------------------------------------------------------
module hamming_syndrome_decode
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int SECDED = 0,
    localparam int P_W    = parity_width(DATA_W),
    localparam int H_W    = DATA_W + P_W
) (
    input  logic [P_W-1:0] i_syn,
    input  logic           i_q,
    output logic [H_W-1:0] o_flip_mask,
    output logic           o_err_single,
    output logic           o_err_uncorr
);

    err_class_e w_class;
    logic       w_syn_nz;
    logic       w_in_range;
    logic       w_flip_en;

    assign w_syn_nz   = (i_syn != '0);
    assign w_in_range = (i_syn <= P_W'(H_W));

    always_comb begin
        w_class = ERR_NONE;
        if (SECDED != 0) begin
            // s==0 with odd parity means only the overall parity bit flipped.
            if (!w_syn_nz)                  w_class = i_q ? ERR_SINGLE : ERR_NONE;
            else if (!i_q || !w_in_range)   w_class = ERR_UNCORR;
            else                            w_class = ERR_SINGLE;
        end else begin
            if (!w_syn_nz)                  w_class = ERR_NONE;
            else if (w_in_range)            w_class = ERR_SINGLE;
            else                            w_class = ERR_UNCORR;
        end
    end

    assign o_err_single = (w_class == ERR_SINGLE);
    assign o_err_uncorr = (w_class == ERR_UNCORR);
    assign w_flip_en    = o_err_single && w_syn_nz;

    always_comb begin
        o_flip_mask = '0;
        for (int i = 0; i < H_W; i++) begin
            o_flip_mask[i] = w_flip_en && (i_syn == P_W'(i + 1));
        end
    end

endmodule

// File: rtl/hamming_sec_corrector.sv
// -----------------------------------------------------------------------------
// hamming_sec_corrector
// Two-stage pipelined Hamming SEC (optionally SECDED) decoder with valid/ready
// handshake on both sides and saturating error-event counters.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        input handshake
//   code_in     N_W          received codeword (bit i = position i+1)
//   out_valid/out_ready      output handshake
//   data_out    DATA_W       corrected data
//   err_pos     P_W          raw syndrome
//   err_single, err_uncorr   error status of data_out
//   cnt_clear                sync clear of both counters
//   cnt_single, cnt_uncorr   CNT_W saturating counts of delivered results
// -----------------------------------------------------------------------------
module hamming_sec_corrector
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int SECDED = 0,
    parameter  int CNT_W  = 16,
    localparam int P_W    = parity_width(DATA_W),
    localparam int H_W    = DATA_W + P_W,
    localparam int N_W    = H_W + ((SECDED != 0) ? 1 : 0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_W-1:0]    code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [P_W-1:0]    err_pos,
    output logic              err_single,
    output logic              err_uncorr,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    logic              r_s1_valid;
    logic [H_W-1:0]    r_s1_code;
    logic [P_W-1:0]    r_s1_syn;
    logic              r_s1_q;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [P_W-1:0]    r_s2_syn;
    logic              r_s2_single;
    logic              r_s2_uncorr;

    logic [CNT_W-1:0]  r_cnt_single;
    logic [CNT_W-1:0]  r_cnt_uncorr;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_out_hs;
    logic [P_W-1:0]    w_syn;
    logic              w_q;
    logic [H_W-1:0]    w_flip;
    logic [H_W-1:0]    w_corr;
    logic [DATA_W-1:0] w_data;
    logic              w_single;
    logic              w_uncorr;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_out_hs = r_s2_valid && out_ready;

    // Syndrome is the XOR of the positions of all set Hamming bits.
    always_comb begin
        w_syn = '0;
        for (int pos = 1; pos <= H_W; pos++) begin
            if (code_in[pos-1]) w_syn = w_syn ^ P_W'(pos);
        end
    end

    assign w_q = ^code_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_q     <= 1'b0;
        end else begin
            if (w_s1_adv) r_s1_valid <= in_valid;
            if (in_valid && w_s1_adv) begin
                r_s1_code <= code_in[H_W-1:0];
                r_s1_syn  <= w_syn;
                r_s1_q    <= w_q;
            end
        end
    end

    hamming_syndrome_decode #(
        .DATA_W (DATA_W),
        .SECDED (SECDED)
    ) u_decode (
        .i_syn        (r_s1_syn),
        .i_q          (r_s1_q),
        .o_flip_mask  (w_flip),
        .o_err_single (w_single),
        .o_err_uncorr (w_uncorr)
    );

    // Uncorrectable words have an all-zero mask, so data passes through raw.
    assign w_corr = r_s1_code ^ w_flip;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_data[i] = w_corr[data_pos(i)-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_s2_syn    <= '0;
            r_s2_single <= 1'b0;
            r_s2_uncorr <= 1'b0;
        end else begin
            if (w_s2_adv) r_s2_valid <= r_s1_valid;
            if (r_s1_valid && w_s2_adv) begin
                r_s2_data   <= w_data;
                r_s2_syn    <= r_s1_syn;
                r_s2_single <= w_single;
                r_s2_uncorr <= w_uncorr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_single <= '0;
            r_cnt_uncorr <= '0;
        end else if (cnt_clear) begin
            r_cnt_single <= '0;
            r_cnt_uncorr <= '0;
        end else if (w_out_hs) begin
            if (r_s2_single && !(&r_cnt_single)) r_cnt_single <= r_cnt_single + CNT_W'(1);
            if (r_s2_uncorr && !(&r_cnt_uncorr)) r_cnt_uncorr <= r_cnt_uncorr + CNT_W'(1);
        end
    end

    assign in_ready   = w_s1_adv;
    assign out_valid  = r_s2_valid;
    assign data_out   = r_s2_data;
    assign err_pos    = r_s2_syn;
    assign err_single = r_s2_single;
    assign err_uncorr = r_s2_uncorr;
    assign cnt_single = r_cnt_single;
    assign cnt_uncorr = r_cnt_uncorr;

endmodule
